// File: rtl/fifo_axis_rd_master.sv
// fifo_axis_rd_master: read side of sync_fifo presented as an AXI4-Stream master.
// A 2-entry skid buffer hides the FIFO's one-cycle registered read latency, so the
// stage sustains one beat per clock while m_tready stays high.
// Optional feature macro: AXIS_TLAST_EN (tlast every BURST_LEN beats; otherwise tlast=0).
module fifo_axis_rd_master #(
    parameter int WIDTH     = 128,
    parameter int BURST_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tlast,
    output logic             busy
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic [WIDTH-1:0] skid_q [2];
    logic [WIDTH-1:0] skid_d [2];
    logic             head_q, head_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;

    logic             pop;
    logic [1:0]       occ_after_pop;
    logic [2:0]       pending;
    logic             wr_slot;

    // Stream outputs and the read-issue decision; tready reaches rd_en combinationally
    // so a pop in this cycle frees a slot for a read issued in the same cycle.
    always_comb begin
        m_tvalid   = (occ_q != 2'd0);
        pop        = m_tvalid & m_tready;
        m_tdata    = skid_q[head_q];
        busy       = (occ_q != 2'd0) | inflight_q;
        // Words already owned by this stage (buffered + in flight) once this pop completes.
        pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = ~rst & enable & ~fifo_empty & (pending < 3'd2);
    end

    // Next-state: advance head on pop, land the in-flight word in the tail slot.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a default
        // first (here, copy of current state) so no latch is inferred on any path.
        skid_d        = skid_q;
        occ_after_pop = occ_q - {1'b0, pop};
        head_d        = head_q ^ pop;
        // Tail slot after this cycle's pop; occ_after_pop is 0 or 1 whenever a capture occurs.
        wr_slot       = head_d ^ occ_after_pop[0];
        if (inflight_q) begin
            skid_d[wr_slot] = fifo_rd_data;
        end
        occ_d      = occ_after_pop + {1'b0, inflight_q};
        inflight_d = fifo_rd_en;
    end

    // State registers with synchronous reset; reset discards buffered and in-flight words.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the buffer storage is reset because m_tdata reads it directly and
            // must show zero out of reset; it is only two words, so this is cheap.
            skid_q[0]  <= '0;
            skid_q[1]  <= '0;
            head_q     <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            head_q     <= head_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef AXIS_TLAST_EN
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // Packet beat counter: advances on each accepted beat, wraps after BURST_LEN beats.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign m_tlast = m_tvalid & (beat_cnt_q == LAST_BEAT);
`else
    logic unused_last_beat;

    assign unused_last_beat = ^LAST_BEAT;
    assign m_tlast          = 1'b0;
`endif

endmodule
